// File: rtl/pll_reconfig_pkg.sv
// Shared constants for the PLL reconfiguration sequencer:
// register map, counter-word layout, status codes and FSM states.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int LO_LSB   = 0;
    localparam int HI_LSB   = 8;
    localparam int BYP_BIT  = 16;
    localparam int ODD_BIT  = 17;
    localparam int CSEL_LSB = 18;

    localparam logic [4:0] CSEL_C0 = 5'd0;

    localparam logic [31:0] MODE_WAITREQ = 32'd0;
    localparam logic [31:0] START_GO     = 32'd1;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_LOCK_TMO = 2'd1;
    localparam logic [1:0] ST_BUS_TMO  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_MODE   = 4'd1,
        S_WR_N      = 4'd2,
        S_WR_M      = 4'd3,
        S_WR_C0     = 4'd4,
        S_WR_START  = 4'd5,
        S_SETTLE    = 4'd6,
        S_LOCK_WAIT = 4'd7,
        S_FINISH    = 4'd8
    } state_t;

    // N/M counter registers take the raw 18-bit word zero-extended.
    function automatic logic [31:0] cnt_word(input logic [17:0] w);
        logic [31:0] r;
        r = '0;
        r[ODD_BIT:LO_LSB] = w;
        return r;
    endfunction

    // C counter register carries the counter select above the word.
    function automatic logic [31:0] c_word(input logic [4:0] sel,
                                           input logic [17:0] w);
        logic [31:0] r;
        r = '0;
        r[ODD_BIT:LO_LSB] = w;
        r[CSEL_LSB +: 5]  = sel;
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Synchronizes pll_locked and judges relock: a run of stable
// locked cycles means ok, too many wait cycles means timeout.
module pll_lock_monitor
    import pll_reconfig_pkg::*;
#(
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pll_locked_i,
    input  logic start_i,
    input  logic clear_i,
    output logic ok_o,
    output logic timeout_o
);

    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);

    logic          sync1_q;
    logic          sync2_q;
    logic [SW-1:0] stable_q;
    logic [TW-1:0] tmo_q;
    logic          lk_s;

    assign lk_s = sync2_q;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
        end
    end

    // Consecutive-lock counter; any unlocked cycle restarts the run.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            stable_q <= '0;
        end else if (start_i) begin
            if (!lk_s) begin
                stable_q <= '0;
            end else if (stable_q != STABLE_MAX) begin
                stable_q <= stable_q + 1'b1;
            end
        end
    end

    // Saturating count of every cycle spent waiting for lock.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            tmo_q <= '0;
        end else if (start_i && tmo_q != TMO_MAX) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    assign ok_o      = start_i && (stable_q == STABLE_MAX);
    assign timeout_o = start_i && (tmo_q == TMO_MAX);

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Drives the PLL reconfig core over Avalon-MM: writes mode and
// N/M/C0 counters, starts the update, then supervises relock.
module pll_reconfig_sequencer
    import pll_reconfig_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int LOCK_STABLE     = 64,
    parameter int LOCK_TIMEOUT    = 100000,
    parameter int WAITREQ_TIMEOUT = 1024
) (
    input  logic        refclk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_read,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int WW = $clog2(WAITREQ_TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [WW-1:0] WR_LAST     = WW'(WAITREQ_TIMEOUT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [17:0]   n_q;
    logic [17:0]   m_q;
    logic [17:0]   c0_q;
    logic [5:0]    addr_q;
    logic [5:0]    addr_d;
    logic [31:0]   wdata_q;
    logic [31:0]   wdata_d;
    logic          write_q;
    logic [WW-1:0] wr_cnt_q;
    logic [SW-1:0] settle_q;
    logic          done_q;
    logic [1:0]    status_q;
    logic          lm_active;
    logic          lm_ok;
    logic          lm_tmo;

    assign lm_active = (state_q == S_LOCK_WAIT);

    pll_lock_monitor #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_mon (
        .clk_i        (refclk),
        .rst_i        (rst),
        .pll_locked_i (pll_locked),
        .start_i      (lm_active),
        .clear_i      (!lm_active),
        .ok_o         (lm_ok),
        .timeout_o    (lm_tmo)
    );

    // Next write in the sequence once the current one completes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_WR_MODE: begin
                state_d = S_WR_N;
                addr_d  = ADDR_N;
                wdata_d = cnt_word(n_q);
            end
            S_WR_N: begin
                state_d = S_WR_M;
                addr_d  = ADDR_M;
                wdata_d = cnt_word(m_q);
            end
            S_WR_M: begin
                state_d = S_WR_C0;
                addr_d  = ADDR_C;
                wdata_d = c_word(CSEL_C0, c0_q);
            end
            S_WR_C0: begin
                state_d = S_WR_START;
                addr_d  = ADDR_START;
                wdata_d = START_GO;
            end
            S_WR_START: begin
                state_d = S_SETTLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Sequencer FSM with registered bus and handshake outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            m_q      <= '0;
            c0_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            wr_cnt_q <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
            status_q <= ST_OK;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_valid) begin
                        n_q      <= cfg_n;
                        m_q      <= cfg_m;
                        c0_q     <= cfg_c0;
                        addr_q   <= ADDR_MODE;
                        wdata_q  <= MODE_WAITREQ;
                        write_q  <= 1'b1;
                        wr_cnt_q <= '0;
                        state_q  <= S_WR_MODE;
                    end
                end
                S_WR_MODE, S_WR_N, S_WR_M,
                S_WR_C0, S_WR_START: begin
                    if (!mgmt_waitrequest) begin
                        wr_cnt_q <= '0;
                        addr_q   <= addr_d;
                        wdata_q  <= wdata_d;
                        state_q  <= state_d;
                        if (state_q == S_WR_START) begin
                            write_q  <= 1'b0;
                            settle_q <= '0;
                        end
                    end else if (wr_cnt_q == WR_LAST) begin
                        write_q  <= 1'b0;
                        status_q <= ST_BUS_TMO;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= S_LOCK_WAIT;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                S_LOCK_WAIT: begin
                    if (lm_ok) begin
                        status_q <= ST_OK;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end else if (lm_tmo) begin
                        status_q <= ST_LOCK_TMO;
                        done_q   <= 1'b1;
                        state_q  <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign status         = status_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = wdata_q;
    assign mgmt_write     = write_q;
    assign mgmt_read      = 1'b0;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Directed bench for the PLL reconfiguration sequencer: nominal,
// stall, lock glitch, lock/bus timeouts, reset and back-pressure.
module tb_pll_reconfig_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [17:0] cfg_n;
    logic [17:0] cfg_m;
    logic [17:0] cfg_c0;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic        mgmt_waitrequest;
    logic        pll_locked;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic done_rdy = 1'b0;

    logic [5:0]  la[$];
    logic [31:0] ld[$];
    int          lc[$];

    pll_reconfig_sequencer #(
        .SETTLE_CYCLES   (16),
        .LOCK_STABLE     (64),
        .LOCK_TIMEOUT    (200),
        .WAITREQ_TIMEOUT (8)
    ) dut (
        .refclk           (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_n            (cfg_n),
        .cfg_m            (cfg_m),
        .cfg_c0           (cfg_c0),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_read        (mgmt_read),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .busy             (busy),
        .done             (done),
        .status           (status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mgmt_write && !mgmt_waitrequest) begin
            la.push_back(mgmt_address);
            ld.push_back(mgmt_writedata);
            lc.push_back(cyc);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_rdy <= cfg_ready;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx,
                          input logic [5:0] a, input logic [31:0] d);
        check({tag, "_present"}, 32'(idx < la.size()), 32'd1);
        if (idx < la.size()) begin
            check({tag, "_addr"}, 32'(la[idx]), 32'(a));
            check({tag, "_data"}, ld[idx], d);
        end
    endtask

    task automatic accept(input logic [17:0] n, input logic [17:0] m,
                          input logic [17:0] c, output int t0);
        cfg_n = n;
        cfg_m = m;
        cfg_c0 = c;
        cfg_valid = 1'b1;
        check("ready_before_accept", 32'(cfg_ready), 32'd1);
        t0 = cyc;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int k;
        k = 0;
        while (done_cnt == base && k < budget) begin
            tick();
            k++;
        end
        check("done_seen", 32'(done_cnt != base), 32'd1);
    endtask

    initial begin
        int t0;
        int lb;
        int db;

        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_n = '0;
        cfg_m = '0;
        cfg_c0 = '0;
        mgmt_waitrequest = 1'b0;
        pll_locked = 1'b1;
        tick();
        tick();
        tick();
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_write", 32'(mgmt_write), 32'd0);
        check("rst_addr", 32'(mgmt_address), 32'd0);
        check("rst_wdata", mgmt_writedata, 32'd0);
        check("rst_read", 32'(mgmt_read), 32'd0);
        rst = 1'b0;
        tick();
        tick();

        // nominal
        lb = la.size();
        db = done_cnt;
        accept(18'h10000, 18'h00404, 18'h00202, t0);
        check("nom_busy", 32'(busy), 32'd1);
        wait_done(db, 200);
        check("nom_latency", 32'(done_cyc - t0), 32'd87);
        check("nom_status", 32'(status), 32'd0);
        check("nom_nwrites", 32'(la.size() - lb), 32'd5);
        chk_wr("nom_mode", lb + 0, 6'h00, 32'h0);
        chk_wr("nom_n", lb + 1, 6'h03, 32'h10000);
        chk_wr("nom_m", lb + 2, 6'h04, 32'h00404);
        chk_wr("nom_c0", lb + 3, 6'h05, 32'h00202);
        chk_wr("nom_start", lb + 4, 6'h02, 32'h1);
        if (lb + 4 < lc.size())
            check("nom_start_cyc", 32'(lc[lb + 4] - t0), 32'd5);
        check("nom_ready_at_done", 32'(done_rdy), 32'd0);
        check("nom_ready_after", 32'(cfg_ready), 32'd1);
        check("nom_busy_after", 32'(busy), 32'd0);
        check("nom_done_pulse", 32'(done), 32'd0);
        check("nom_write_idle", 32'(mgmt_write), 32'd0);
        tick();

        // waitrequest stall on the M write
        lb = la.size();
        db = done_cnt;
        accept(18'h10000, 18'h00404, 18'h00202, t0);
        tick();
        tick();
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_write", 32'(mgmt_write), 32'd1);
            check("stall_addr", 32'(mgmt_address), 32'h04);
            check("stall_data", mgmt_writedata, 32'h00404);
            tick();
        end
        mgmt_waitrequest = 1'b0;
        check("stall_write4", 32'(mgmt_write), 32'd1);
        check("stall_addr4", 32'(mgmt_address), 32'h04);
        check("stall_data4", mgmt_writedata, 32'h00404);
        wait_done(db, 200);
        check("stall_latency", 32'(done_cyc - t0), 32'd90);
        check("stall_nwrites", 32'(la.size() - lb), 32'd5);
        chk_wr("stall_m", lb + 2, 6'h04, 32'h00404);
        chk_wr("stall_c0", lb + 3, 6'h05, 32'h00202);
        if (lb + 2 < lc.size())
            check("stall_m_cyc", 32'(lc[lb + 2] - t0), 32'd6);
        check("stall_status", 32'(status), 32'd0);
        tick();

        // one-cycle lock glitch after 40 stable cycles
        db = done_cnt;
        accept(18'h10000, 18'h00404, 18'h00202, t0);
        while (cyc < t0 + 60) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        wait_done(db, 300);
        check("glitch_latency", 32'(done_cyc - t0), 32'd128);
        check("glitch_status", 32'(status), 32'd0);
        tick();

        // lock never arrives
        pll_locked = 1'b0;
        tick();
        tick();
        tick();
        lb = la.size();
        db = done_cnt;
        accept(18'h10000, 18'h00404, 18'h00202, t0);
        wait_done(db, 400);
        check("ltmo_latency", 32'(done_cyc - t0), 32'd223);
        check("ltmo_status", 32'(status), 32'd1);
        check("ltmo_nwrites", 32'(la.size() - lb), 32'd5);
        pll_locked = 1'b1;
        tick();
        tick();
        tick();

        // waitrequest stuck on the N write
        lb = la.size();
        db = done_cnt;
        accept(18'h10000, 18'h00404, 18'h00202, t0);
        tick();
        mgmt_waitrequest = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("btmo_write", 32'(mgmt_write), 32'd1);
            check("btmo_addr", 32'(mgmt_address), 32'h03);
            tick();
        end
        check("btmo_write_drop", 32'(mgmt_write), 32'd0);
        check("btmo_done", 32'(done), 32'd1);
        check("btmo_status", 32'(status), 32'd2);
        mgmt_waitrequest = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("btmo_nwrites", 32'(la.size() - lb), 32'd1);
        check("btmo_ndone", 32'(done_cnt - db), 32'd1);
        check("btmo_status_hold", 32'(status), 32'd2);
        check("btmo_idle", 32'(busy), 32'd0);

        // reset during the C0 write
        db = done_cnt;
        accept(18'h00101, 18'h00202, 18'h00303, t0);
        tick();
        tick();
        tick();
        check("rstop_c0_addr", 32'(mgmt_address), 32'h05);
        check("rstop_c0_write", 32'(mgmt_write), 32'd1);
        rst = 1'b1;
        tick();
        check("rstop_write", 32'(mgmt_write), 32'd0);
        check("rstop_busy", 32'(busy), 32'd0);
        check("rstop_ready", 32'(cfg_ready), 32'd1);
        check("rstop_addr", 32'(mgmt_address), 32'd0);
        check("rstop_status", 32'(status), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) tick();
        check("rstop_no_done", 32'(done_cnt - db), 32'd0);
        check("rstop_still_idle", 32'(busy), 32'd0);

        // cfg_valid while busy is ignored
        lb = la.size();
        db = done_cnt;
        accept(18'h20305, 18'h00000, 18'h3ffff, t0);
        cfg_valid = 1'b1;
        cfg_n = 18'h3aaaa;
        cfg_m = 18'h15555;
        cfg_c0 = 18'h0f0f0;
        for (int i = 0; i < 30; i++) begin
            check("bp_ready_low", 32'(cfg_ready), 32'd0);
            tick();
        end
        cfg_valid = 1'b0;
        wait_done(db, 200);
        check("bp_latency", 32'(done_cyc - t0), 32'd87);
        check("bp_nwrites", 32'(la.size() - lb), 32'd5);
        chk_wr("bp_n", lb + 1, 6'h03, 32'h20305);
        chk_wr("bp_m", lb + 2, 6'h04, 32'h00000);
        chk_wr("bp_c0", lb + 3, 6'h05, 32'h3ffff);
        for (int i = 0; i < 10; i++) tick();
        check("bp_ndone", 32'(done_cnt - db), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/pll_reconfig_sequencer.md
Name: pll_reconfig_sequencer

Overview:
- Sequences dynamic reconfiguration of the system PLL (Cyclone V, reconfigurable subtype) through the Altera PLL reconfiguration core's Avalon-MM management port.
- Accepts one counter-set request at a time: N, M and C0 high/low counts plus bypass and odd-duty flags.
- Writes the request into the reconfiguration core, issues start, then supervises relock with settle, stability and timeout checks.
- Sits between the system control/CSR logic and the reconfiguration core that drives reconfig_to_pll.

Parameters:
- SETTLE_CYCLES, 16, cycles after the start write before lock is sampled.
- LOCK_STABLE, 64, consecutive synchronized-locked cycles required to declare success.
- LOCK_TIMEOUT, 100000, maximum cycles in the lock-wait phase before error.
- WAITREQ_TIMEOUT, 1024, maximum cycles a single bus write may stall on waitrequest.

Ports:
- refclk  in  1  management clock (50 MHz reference domain).
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_n  in  18  N counter word: [7:0] lo, [15:8] hi (0 encodes 256), [16] bypass, [17] odd-duty.
- cfg_m  in  18  M counter word, same format.
- cfg_c0  in  18  C0 counter word, same format.
- mgmt_address  out  6  reconfig register address.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_read  out  1  tied 0.
- mgmt_waitrequest  in  1  stall from the reconfiguration core.
- pll_locked  in  1  PLL locked, asynchronous to refclk.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on completion.
- status  out  2  result of the last request: 0 ok, 1 lock timeout, 2 bus timeout. Held until the next done.

Behaviour:
- Reset values:
  - cfg_ready=1, busy=0, done=0, status=0.
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0.
  - All counters cleared; synchronizer flops cleared.
- pll_locked passes through a 2-flop synchronizer; lk_s denotes the synchronized value.
- Accept: a handshake occurs when cfg_valid && cfg_ready. cfg_n, cfg_m and cfg_c0 are captured into internal registers on that cycle. cfg_valid while busy is ignored.
- States: IDLE -> WR_MODE -> WR_N -> WR_M -> WR_C0 -> WR_START -> SETTLE -> LOCK_WAIT -> FINISH -> IDLE.
- Bus writes (one per WR_* state):

  | State | Address | Data |
  |---|---|---|
  | WR_MODE | 0x00 | 0 (waitrequest mode) |
  | WR_N | 0x03 | {14'b0, n} |
  | WR_M | 0x04 | {14'b0, m} |
  | WR_C0 | 0x05 | {9'b0, 5'd0 (counter select C0), c0} |
  | WR_START | 0x02 | 1 |

- Write rules:
  - In each WR_* state, mgmt_write=1 and address/data are held stable while mgmt_waitrequest=1.
  - The write completes on the first cycle with mgmt_write=1 && mgmt_waitrequest=0; the FSM advances on the next edge.
  - Writes are back-to-back, so with zero wait states WR_MODE..WR_START take exactly 5 cycles.
  - mgmt_write is 0 outside WR_* states.
- Bus timeout:
  - A per-write stall counter clears on entry to each WR_* state.
  - When it reaches WAITREQ_TIMEOUT with waitrequest still high: deassert mgmt_write, status=2, go to FINISH.
- SETTLE: count SETTLE_CYCLES, ignoring lk_s, then go to LOCK_WAIT.
- LOCK_WAIT:
  - stable_cnt increments while lk_s=1 and clears to 0 when lk_s=0.
  - stable_cnt reaching LOCK_STABLE -> status=0, FINISH.
  - The timeout counter counts every LOCK_WAIT cycle. Reaching LOCK_TIMEOUT -> status=1, FINISH.
  - If both conditions hit on the same cycle, success wins.
- FINISH: done=1 for exactly 1 cycle, then IDLE. cfg_ready returns high in IDLE on the following cycle.
- Counter widths are $clog2(param+1); counters saturate and never wrap.
- rst asserted mid-operation: on the next edge, return to IDLE with all reset values. mgmt_write drops immediately. No done pulse; the partial PLL configuration is abandoned.
- Latency, zero wait states, PLL already locked: accept at cycle 0, start write at cycle 5, done at cycle 5+SETTLE_CYCLES+LOCK_STABLE+2.

Decomposition:
- Shared package pll_reconfig_pkg holds:
  - register address constants (MODE, START, N, M, C counters);
  - the counter-word field offsets (lo, hi, bypass, odd-duty, C select);
  - the status code constants.
- One sub-module: pll_lock_monitor. It contains the synchronizer, the stable counter and the timeout counter. Its interface is start/clear in and ok/timeout pulse outputs.
- The FSM and bus driver stay in the top module.

Test Plan:
- Nominal, no wait states:
  - Stimulus: cfg_n=0x10000 (bypass), cfg_m=0x00404, cfg_c0=0x00202; pll_locked=1.
  - Required: writes in order (0x00, 0), (0x03, 0x10000), (0x04, 0x404), (0x05, 0x202), (0x02, 1); done at cycle 87; status=0.
- Waitrequest stall:
  - Stimulus: mgmt_waitrequest held 3 cycles on the M write.
  - Required: address/data stable for all 4 cycles; exactly one completed write per register; done delayed by 3 cycles.
- Lock glitch:
  - Stimulus: pll_locked toggles low for 1 cycle after 40 stable cycles.
  - Required: stable count restarts; done arrives 40+ cycles later than nominal; status=0.
- Lock timeout:
  - Stimulus: pll_locked held 0, LOCK_TIMEOUT=200.
  - Required: done at 200 LOCK_WAIT cycles; status=1.
- Bus timeout:
  - Stimulus: waitrequest stuck 1 on the N write, WAITREQ_TIMEOUT=8.
  - Required: mgmt_write deasserts after 8 cycles; status=2; later writes not issued.
- Reset and back-pressure:
  - Stimulus: rst during the C0 write; separately, cfg_valid asserted while busy.
  - Required: on rst, mgmt_write=0 next cycle, IDLE, no done. The request made while busy is not captured; cfg_ready=0 throughout.
